// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC / IF-ID controller for the pipelined CPU.
// Each cycle it decides whether the PC advances and which value it loads.
// The choices are sequential, branch target, jump target, or hold.
// It also arbitrates load-use stalls and branch/jump redirects.
// It handles a variable-latency instruction-memory handshake.
// Outputs are purely combinational from the registered state and the inputs.
module fetch_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          CNT_W        = 16,
  parameter int          MAX_WAIT     = 255
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [31:0]      pc_i,
  input  logic             load_use_i,
  input  logic             branch_taken_i,
  input  logic [31:0]      branch_target_i,
  input  logic             jump_i,
  input  logic [31:0]      jump_target_i,
  output logic             imem_req_o,
  input  logic             imem_ack_i,
  output logic [31:0]      pc_next_o,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             idex_bubble_o,
  output logic             err_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_ERROR = 2'd3;

  localparam int WAIT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

  logic [1:0]        r_state;
  logic              r_pendValid;
  logic [31:0]       r_pendTarget;
  logic [WAIT_W-1:0] r_waitCnt;
  logic [CNT_W-1:0]  r_stallCnt;
  logic              r_err;

  logic              w_redir;
  logic [31:0]       w_target;
  logic [1:0]        w_nextState;
  logic              w_pendLatch;
  logic              w_pendApply;
  logic              w_waitClr;
  logic              w_waitIncEn;
  logic [WAIT_W-1:0] w_waitInc;
  logic              w_stallCycle;

  // A redirect counts only when the branch/jump in ID is not itself stalled by a load-use hazard; jump wins over branch.
  always_comb begin
    w_redir   = (jump_i | branch_taken_i) & ~load_use_i;
    w_target  = jump_i ? jump_target_i : branch_target_i;
    w_waitInc = r_waitCnt + WAIT_W'(1);
  end

  // Per-state output decode and next-state selection.
  always_comb begin
    imem_req_o    = 1'b0;
    pc_next_o     = pc_i;
    pc_write_o    = 1'b0;
    ifid_write_o  = 1'b0;
    ifid_flush_o  = 1'b0;
    idex_bubble_o = 1'b0;
    w_nextState   = r_state;
    w_pendLatch   = 1'b0;
    w_pendApply   = 1'b0;
    w_waitClr     = 1'b0;
    w_waitIncEn   = 1'b0;
    case (r_state)
      S_IDLE: begin
        pc_next_o = RESET_VECTOR;
        if (start_i) begin
          w_nextState = S_FETCH;
        end
      end
      S_FETCH, S_WAIT: begin
        imem_req_o = 1'b1;
        if (imem_ack_i) begin
          if (r_pendValid || w_redir) begin
            pc_next_o    = r_pendValid ? r_pendTarget : w_target;
            pc_write_o   = 1'b1;
            ifid_write_o = 1'b1;
            ifid_flush_o = 1'b1;
            w_pendApply  = 1'b1;
          end else if (load_use_i) begin
            idex_bubble_o = 1'b1;
          end else begin
            pc_next_o    = pc_i + 32'd4;
            pc_write_o   = 1'b1;
            ifid_write_o = 1'b1;
          end
          if (r_state == S_WAIT) begin
            w_nextState = S_FETCH;
            w_waitClr   = 1'b1;
          end
        end else begin
          if (load_use_i) begin
            idex_bubble_o = 1'b1;
          end else begin
            ifid_write_o = 1'b1;
            ifid_flush_o = 1'b1;
          end
          w_pendLatch = w_redir;
          if (r_state == S_FETCH) begin
            w_nextState = S_WAIT;
          end else begin
            w_waitIncEn = 1'b1;
            if (w_waitInc == WAIT_W'(MAX_WAIT)) begin
              w_nextState = S_ERROR;
            end
          end
        end
      end
      default: begin
        ifid_flush_o = 1'b1;
      end
    endcase
  end

  // A stall cycle is any active fetch cycle in which the PC is held.
  always_comb begin
    w_stallCycle = ((r_state == S_FETCH) || (r_state == S_WAIT)) && !pc_write_o;
  end

  // State, pending redirect, wait timer, stall counter and sticky error register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= S_IDLE;
      r_pendValid  <= 1'b0;
      r_pendTarget <= 32'd0;
      r_waitCnt    <= '0;
      r_stallCnt   <= '0;
      r_err        <= 1'b0;
    end else begin
      r_state <= w_nextState;
      if (w_pendApply) begin
        r_pendValid <= 1'b0;
      end else if (w_pendLatch) begin
        r_pendValid  <= 1'b1;
        r_pendTarget <= w_target;
      end
      if (w_waitClr) begin
        r_waitCnt <= '0;
      end else if (w_waitIncEn) begin
        r_waitCnt <= w_waitInc;
      end
      if (w_stallCycle && (r_stallCnt != {CNT_W{1'b1}})) begin
        r_stallCnt <= r_stallCnt + CNT_W'(1);
      end
      if (w_nextState == S_ERROR) begin
        r_err <= 1'b1;
      end
    end
  end

  // Registered status straight to the ports.
  always_comb begin
    err_o       = r_err;
    state_o     = r_state;
    stall_cnt_o = r_stallCnt;
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: table-driven vectors for fetch_sequencer.
// Each record holds one cycle's inputs plus the outputs expected during that cycle.
// Records are queued as they are driven and compared mid-cycle.
module tb_fetch_sequencer;

  localparam logic [31:0] RV = 32'h0000_0080;

  // Flag order: req, pc_write, ifid_write, ifid_flush, idex_bubble, err.
  localparam logic [5:0] F_IDLE  = 6'b000000;
  localparam logic [5:0] F_SEQ   = 6'b111000;
  localparam logic [5:0] F_REDIR = 6'b111100;
  localparam logic [5:0] F_LU    = 6'b100010;
  localparam logic [5:0] F_NOP   = 6'b101100;
  localparam logic [5:0] F_ERR   = 6'b000101;

  typedef struct {
    string       name;
    logic        rst;
    logic        start;
    logic        lu;
    logic        br;
    logic        jmp;
    logic        ack;
    logic [31:0] pc;
    logic [31:0] bt;
    logic [31:0] jt;
    logic [31:0] eNext;
    logic [5:0]  eFlags;
    logic [1:0]  eState;
    logic [3:0]  eStall;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] pc;
  logic        loadUse;
  logic        brTaken;
  logic [31:0] brTarget;
  logic        jmp;
  logic [31:0] jmpTarget;
  logic        imemReq;
  logic        imemAck;
  logic [31:0] pcNext;
  logic        pcWrite;
  logic        ifidWrite;
  logic        ifidFlush;
  logic        idexBubble;
  logic        err;
  logic [1:0]  state;
  logic [3:0]  stallCnt;

  vec_t vecs[$];
  vec_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  fetch_sequencer #(
    .RESET_VECTOR(RV),
    .CNT_W(4),
    .MAX_WAIT(4)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .start_i(start),
    .pc_i(pc),
    .load_use_i(loadUse),
    .branch_taken_i(brTaken),
    .branch_target_i(brTarget),
    .jump_i(jmp),
    .jump_target_i(jmpTarget),
    .imem_req_o(imemReq),
    .imem_ack_i(imemAck),
    .pc_next_o(pcNext),
    .pc_write_o(pcWrite),
    .ifid_write_o(ifidWrite),
    .ifid_flush_o(ifidFlush),
    .idex_bubble_o(idexBubble),
    .err_o(err),
    .state_o(state),
    .stall_cnt_o(stallCnt)
  );

  // Free-running 10-time-unit clock.
  always #5 clk = ~clk;

  function automatic void addVec(input string name, input logic r, input logic s,
                                 input logic lu, input logic br, input logic jp,
                                 input logic ack, input logic [31:0] p,
                                 input logic [31:0] bt, input logic [31:0] jt,
                                 input logic [31:0] eNext, input logic [5:0] eFlags,
                                 input logic [1:0] eState, input logic [3:0] eStall);
    vec_t v;
    v.name = name; v.rst = r; v.start = s; v.lu = lu; v.br = br; v.jmp = jp;
    v.ack = ack; v.pc = p; v.bt = bt; v.jt = jt; v.eNext = eNext;
    v.eFlags = eFlags; v.eState = eState; v.eStall = eStall;
    vecs.push_back(v);
  endfunction

  task automatic applyStimulus(input vec_t v);
    @(posedge clk);
    #1;
    rst = v.rst; start = v.start; loadUse = v.lu; brTaken = v.br; jmp = v.jmp;
    imemAck = v.ack; pc = v.pc; brTarget = v.bt; jmpTarget = v.jt;
    sb.push_back(v);
  endtask

  task automatic checkOutput();
    vec_t e;
    logic [5:0] gotFlags;
    @(negedge clk);
    e = sb.pop_front();
    gotFlags = {imemReq, pcWrite, ifidWrite, ifidFlush, idexBubble, err};
    vectors++;
    if ({pcNext, gotFlags, state, stallCnt} !== {e.eNext, e.eFlags, e.eState, e.eStall}) begin
      miscompares++;
      $display("[TB] FAIL %s: got next=%h flags=%b state=%0d stall=%0d, want next=%h flags=%b state=%0d stall=%0d",
               e.name, pcNext, gotFlags, state, stallCnt, e.eNext, e.eFlags, e.eState, e.eStall);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; loadUse = 1'b0; brTaken = 1'b0; jmp = 1'b0;
    imemAck = 1'b0; pc = 32'd0; brTarget = 32'd0; jmpTarget = 32'd0;

    //       name           rst st lu br jp ack pc            bt       jt       next          flags    st stall
    addVec("rst_idle",      1, 0, 0, 0, 0, 0, 32'h0,        32'h0,   32'h0,   RV,           F_IDLE,  0, 0);
    addVec("start",         0, 1, 0, 0, 0, 0, 32'h0,        32'h0,   32'h0,   RV,           F_IDLE,  0, 0);
    addVec("seq0",          0, 0, 0, 0, 0, 1, 32'h100,      32'h0,   32'h0,   32'h104,      F_SEQ,   1, 0);
    addVec("seq1_start_ign",0, 1, 0, 0, 0, 1, 32'h104,      32'h0,   32'h0,   32'h108,      F_SEQ,   1, 0);
    addVec("lu_masks_br",   0, 0, 1, 1, 0, 1, 32'h108,      32'h200, 32'h0,   32'h108,      F_LU,    1, 0);
    addVec("br_taken",      0, 0, 0, 1, 0, 1, 32'h108,      32'h200, 32'h0,   32'h200,      F_REDIR, 1, 1);
    addVec("jmp_priority",  0, 0, 0, 1, 1, 1, 32'h200,      32'h500, 32'h300, 32'h300,      F_REDIR, 1, 1);
    addVec("miss_fetch",    0, 0, 0, 0, 0, 0, 32'h300,      32'h0,   32'h0,   32'h300,      F_NOP,   1, 1);
    addVec("wait_jmp",      0, 0, 0, 0, 1, 0, 32'h300,      32'h0,   32'h400, 32'h300,      F_NOP,   2, 2);
    addVec("wait_hold",     0, 0, 0, 0, 0, 0, 32'h300,      32'h0,   32'h0,   32'h300,      F_NOP,   2, 3);
    addVec("ack_pending",   0, 0, 0, 0, 0, 1, 32'h300,      32'h0,   32'h0,   32'h400,      F_REDIR, 2, 4);
    addVec("pending_clr",   0, 0, 0, 0, 0, 1, 32'h400,      32'h0,   32'h0,   32'h404,      F_SEQ,   1, 4);
    addVec("miss_lu",       0, 0, 1, 0, 1, 0, 32'h404,      32'h0,   32'h600, 32'h404,      F_LU,    1, 4);
    addVec("wait_br",       0, 0, 0, 1, 0, 0, 32'h404,      32'h700, 32'h0,   32'h404,      F_NOP,   2, 5);
    addVec("wait_newest",   0, 0, 0, 0, 1, 0, 32'h404,      32'h0,   32'h800, 32'h404,      F_NOP,   2, 6);
    addVec("ack_pend_lu",   0, 0, 1, 0, 0, 1, 32'h404,      32'h0,   32'h0,   32'h800,      F_REDIR, 2, 7);
    addVec("after_redir",   0, 0, 0, 0, 0, 1, 32'h800,      32'h0,   32'h0,   32'h804,      F_SEQ,   1, 7);
    addVec("pc_wrap",       0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC,32'h0,   32'h0,   32'h0,        F_SEQ,   1, 7);
    for (int i = 0; i < 10; i++) begin
      addVec("stall_sat",   0, 0, 1, 0, 0, 1, 32'h0,        32'h0,   32'h0,   32'h0,        F_LU,    1,
             (7 + i > 15) ? 4'd15 : 4'(7 + i));
    end
    addVec("seq_sat",       0, 0, 0, 0, 0, 1, 32'h10,       32'h0,   32'h0,   32'h14,       F_SEQ,   1, 15);
    addVec("miss_jmp",      0, 0, 0, 0, 1, 0, 32'h14,       32'h0,   32'h900, 32'h14,       F_NOP,   1, 15);
    addVec("rst_in_wait",   1, 0, 0, 0, 0, 0, 32'h14,       32'h0,   32'h0,   32'h14,       F_NOP,   2, 15);
    addVec("late_ack_idle", 0, 0, 0, 0, 0, 1, 32'h14,       32'h0,   32'h0,   RV,           F_IDLE,  0, 0);
    addVec("restart",       0, 1, 0, 0, 0, 0, 32'h14,       32'h0,   32'h0,   RV,           F_IDLE,  0, 0);
    addVec("pending_lost",  0, 0, 0, 0, 0, 1, 32'h20,       32'h0,   32'h0,   32'h24,       F_SEQ,   1, 0);
    addVec("to_wait",       0, 0, 0, 0, 0, 0, 32'h24,       32'h0,   32'h0,   32'h24,       F_NOP,   1, 0);
    for (int i = 0; i < 4; i++) begin
      addVec("wait_timeout",0, 0, 0, 0, 0, 0, 32'h24,       32'h0,   32'h0,   32'h24,       F_NOP,   2, 4'(i + 1));
    end
    addVec("error",         0, 0, 1, 1, 1, 1, 32'h24,       32'h500, 32'h600, 32'h24,       F_ERR,   3, 5);
    addVec("err_sticky",    0, 1, 0, 0, 0, 1, 32'h24,       32'h0,   32'h0,   32'h24,       F_ERR,   3, 5);
    addVec("rst_in_err",    1, 0, 0, 0, 0, 0, 32'h24,       32'h0,   32'h0,   32'h24,       F_ERR,   3, 5);
    addVec("err_cleared",   0, 0, 0, 0, 0, 0, 32'h24,       32'h0,   32'h0,   RV,           F_IDLE,  0, 0);

    repeat (2) @(posedge clk);
    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
